// File: rtl/matrix_row_accumulator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_row_accumulator_if : element stream in, row result out            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface matrix_row_accumulator_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/matrix_row_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_row_accumulator : folds LEN add/sub elements into one row sum     |
// | Optional: ACC_SATURATE_EN clamps acc on signed overflow                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module matrix_row_accumulator #(
  parameter int WIDTH = 16,
  parameter int LEN   = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  matrix_row_accumulator_if.slave  bus
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_last = CNT_W'(LEN - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic             r_ovf;

  logic             w_accept;
  logic             w_first;
  logic             w_last;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum_ext;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_uevt;
  logic             w_sevt;

  assign w_accept  = bus.in_valid && (r_state == ACCUM);
  assign w_first   = (r_count == '0);
  assign w_last    = (r_count == c_last);

  // Subtract is a + ~b + 1, so the carry-in doubles as the sub flag.
  assign w_a       = w_first ? '0 : r_acc;
  assign w_b       = bus.in_sub ? ~bus.in_data : bus.in_data;
  assign w_sum_ext = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, bus.in_sub};
  assign w_sum     = w_sum_ext[WIDTH-1:0];
  assign w_uevt    = w_sum_ext[WIDTH] ^ bus.in_sub;
  assign w_sevt    = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);

`ifdef ACC_SATURATE_EN
  // Overflow direction follows the shared operand sign.
  assign w_acc_nxt = !w_sevt       ? w_sum :
                     w_a[WIDTH-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                     {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_acc_nxt = w_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_accept && w_last) w_state_nxt = HOLD;
      HOLD:    if (bus.out_ready)      w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_acc_nxt;
      r_carry <= (r_carry && !w_first) || w_uevt;
      r_ovf   <= (r_ovf && !w_first) || w_sevt;
      r_count <= w_last ? '0 : r_count + 1'b1;
    end
  end

  assign bus.in_ready  = (r_state == ACCUM);
  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_sum   = r_acc;
  assign bus.out_carry = r_carry;
  assign bus.out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_matrix_row_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_matrix_row_accumulator : directed + random rows vs arithmetic model   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_matrix_row_accumulator;

  logic clk;
  logic rst_n;

  // Index 0 drives the LEN=4 instance, index 1 the LEN=1 instance.
  logic        vld [2];
  logic [15:0] dat [2];
  logic        sb  [2];
  logic        ordy[2];
  logic        rdy [2];
  logic        ov  [2];
  logic [15:0] osum[2];
  logic        ocar[2];
  logic        oovf[2];

  int n_tests;
  int n_fail;

  logic [15:0] q_d[$];
  bit          q_s[$];

  matrix_row_accumulator_if #(.WIDTH(16)) bus4 ();
  matrix_row_accumulator_if #(.WIDTH(16)) bus1 ();

  assign bus4.in_valid  = vld[0];
  assign bus4.in_data   = dat[0];
  assign bus4.in_sub    = sb[0];
  assign bus4.out_ready = ordy[0];
  assign rdy[0]  = bus4.in_ready;
  assign ov[0]   = bus4.out_valid;
  assign osum[0] = bus4.out_sum;
  assign ocar[0] = bus4.out_carry;
  assign oovf[0] = bus4.out_ovf;

  assign bus1.in_valid  = vld[1];
  assign bus1.in_data   = dat[1];
  assign bus1.in_sub    = sb[1];
  assign bus1.out_ready = ordy[1];
  assign rdy[1]  = bus1.in_ready;
  assign ov[1]   = bus1.out_valid;
  assign osum[1] = bus1.out_sum;
  assign ocar[1] = bus1.out_carry;
  assign oovf[1] = bus1.out_ovf;

  matrix_row_accumulator #(.WIDTH(16), .LEN(4), .CNT_W(8)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  matrix_row_accumulator #(.WIDTH(16), .LEN(1), .CNT_W(8)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer model of one row: true signed/unsigned results, then wrap or clamp.
  function automatic void model(output logic [15:0] es, output bit ec, output bit eo);
    int ua, as_v, du, ds, tu, ts;
    ua = 0;
    ec = 1'b0;
    eo = 1'b0;
    foreach (q_d[i]) begin
      du   = int'(q_d[i]);
      ds   = (du >= 32768) ? du - 65536 : du;
      as_v = (ua >= 32768) ? ua - 65536 : ua;
      if (!q_s[i]) begin
        tu = ua + du;
        ts = as_v + ds;
        if (tu > 65535) ec = 1'b1;
      end else begin
        tu = ua - du;
        ts = as_v - ds;
        if (du > ua) ec = 1'b1;
      end
      ua = tu & 32'hFFFF;
      if (ts > 32767 || ts < -32768) begin
        eo = 1'b1;
`ifdef ACC_SATURATE_EN
        ua = (ts > 0) ? 32767 : 32768;
`endif
      end
    end
    es = ua[15:0];
    q_d.delete();
    q_s.delete();
  endfunction

  task automatic push(input int k, input logic [15:0] d, input bit s, input bit keep);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    vld[k] = 1'b1;
    dat[k] = d;
    sb[k]  = s;
    while (!got && n < 50) begin
      got = rdy[k];
      @(posedge clk);
      #1;
      n++;
    end
    if (!keep) vld[k] = 1'b0;
    q_d.push_back(d);
    q_s.push_back(s);
    n_tests++;
    if (got !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout dut=%0d: accepted=%0b, required 1", k, got);
    end
  endtask

  task automatic get_result(input int k, input string name, input int delay);
    logic [15:0] es;
    bit          ec, eo;
    model(es, ec, eo);
    n_tests++;
    if (ov[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency: out_valid=%0b, required 1", name, ov[k]);
    end
    for (int c = 0; c < delay; c++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (ov[k] !== 1'b1 || rdy[k] !== 1'b0 || osum[k] !== es) begin
        n_fail++;
        $display("FAIL %s hold: valid=%0b ready=%0b sum=%h, required 1 0 %h",
                 name, ov[k], rdy[k], osum[k], es);
      end
    end
    n_tests++;
    if (osum[k] !== es) begin
      n_fail++;
      $display("FAIL %s sum: got %h, required %h", name, osum[k], es);
    end
    n_tests++;
    if (ocar[k] !== ec) begin
      n_fail++;
      $display("FAIL %s carry: got %0b, required %0b", name, ocar[k], ec);
    end
    n_tests++;
    if (oovf[k] !== eo) begin
      n_fail++;
      $display("FAIL %s ovf: got %0b, required %0b", name, oovf[k], eo);
    end
    n_tests++;
    if (rdy[k] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s in_ready_in_hold: got %0b, required 0", name, rdy[k]);
    end
    ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    ordy[k] = 1'b0;
    n_tests++;
    if (ov[k] !== 1'b0 || rdy[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: valid=%0b ready=%0b, required 0 1", name, ov[k], rdy[k]);
    end
  endtask

  task automatic check_idle(input string name);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (ov[k] !== 1'b0 || rdy[k] !== 1'b1 || osum[k] !== 16'h0 ||
          ocar[k] !== 1'b0 || oovf[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s dut=%0d: valid=%0b ready=%0b sum=%h c=%0b o=%0b, required 0 1 0000 0 0",
                 name, k, ov[k], rdy[k], osum[k], ocar[k], oovf[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_asserted");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle("reset_released");
  endtask

  task automatic test_basic_add();
    push(0, 16'd1, 1'b0, 1'b0);
    push(0, 16'd2, 1'b0, 1'b0);
    push(0, 16'd3, 1'b0, 1'b0);
    push(0, 16'd4, 1'b0, 1'b0);
    get_result(0, "basic_add", 0);
  endtask

  task automatic test_wrap();
    push(1, 16'hFFFF, 1'b0, 1'b0);
    get_result(1, "len1_ffff", 0);
    push(1, 16'h0001, 1'b0, 1'b0);
    get_result(1, "len1_one", 0);
    // Trailing zeros leave the two-element wrap sum and carry untouched.
    push(0, 16'hFFFF, 1'b0, 1'b0);
    push(0, 16'h0001, 1'b0, 1'b0);
    push(0, 16'h0000, 1'b0, 1'b0);
    push(0, 16'h0000, 1'b0, 1'b0);
    get_result(0, "wrap_carry", 0);
  endtask

  task automatic test_overflow();
    push(0, 16'h7FFF, 1'b0, 1'b0);
    push(0, 16'h0001, 1'b0, 1'b0);
    push(0, 16'h0000, 1'b0, 1'b0);
    push(0, 16'h0000, 1'b0, 1'b0);
    get_result(0, "signed_ovf", 0);
  endtask

  task automatic test_borrow();
    push(0, 16'd5, 1'b0, 1'b0);
    push(0, 16'd7, 1'b1, 1'b0);
    push(0, 16'd0, 1'b0, 1'b0);
    push(0, 16'd0, 1'b0, 1'b0);
    get_result(0, "borrow", 0);
    for (int i = 0; i < 4; i++) push(0, 16'd3, 1'b0, 1'b0);
    get_result(0, "flags_cleared", 0);
  endtask

  task automatic test_backpressure();
    push(0, 16'd10, 1'b0, 1'b0);
    push(0, 16'd20, 1'b1, 1'b0);
    push(0, 16'd30, 1'b0, 1'b0);
    push(0, 16'h1234, 1'b0, 1'b1);
    dat[0] = 16'h0BAD;
    sb[0]  = 1'b0;
    get_result(0, "backpressure", 5);
    push(0, 16'h0BAD, 1'b0, 1'b0);
    push(0, 16'd1, 1'b0, 1'b0);
    push(0, 16'd2, 1'b1, 1'b0);
    push(0, 16'd3, 1'b0, 1'b0);
    get_result(0, "after_backpressure", 0);
  endtask

  task automatic test_async_reset();
    push(0, 16'd100, 1'b0, 1'b0);
    push(0, 16'd200, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    q_d.delete();
    q_s.delete();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(0, 16'd7, 1'b0, 1'b0);
    push(0, 16'd8, 1'b0, 1'b0);
    push(0, 16'd9, 1'b1, 1'b0);
    push(0, 16'd1, 1'b0, 1'b0);
    get_result(0, "post_reset_row", 0);
  endtask

  function automatic logic [15:0] pick_data();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      for (int e = 0; e < 4; e++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        push(0, pick_data(), 1'($urandom_range(0, 1)), 1'b0);
      end
      get_result(0, "random_len4", $urandom_range(0, 3));
    end
    for (int r = 0; r < 6; r++) begin
      push(1, pick_data(), 1'($urandom_range(0, 1)), 1'b0);
      get_result(1, "random_len1", $urandom_range(0, 2));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vld[k]  = 1'b0;
      dat[k]  = 16'h0;
      sb[k]   = 1'b0;
      ordy[k] = 1'b0;
    end
    test_reset();
    test_basic_add();
    test_wrap();
    test_overflow();
    test_borrow();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
